// File: rtl/score_keeper.sv
// Frogger score accumulator: saturating awards, high score retention,
// new-high flag and extra-life pulses at fixed score spacing.
module score_keeper #(
  parameter int unsigned SCORE_W   = 16,
  parameter int unsigned LEVEL_W   = 4,
  parameter int unsigned TIME_W    = 6,
  parameter int unsigned TIME_MAX  = 60,
  parameter int unsigned LEVEL_PTS = 50,
  parameter int unsigned TIME_PTS  = 10,
  parameter int unsigned HOME_PTS  = 1000,
  parameter int unsigned STEP_PTS  = 10,
  parameter int unsigned LIFE_PTS  = 10000
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               new_game,
  input  logic               game_over,
  input  logic [LEVEL_W-1:0] level,
  input  logic [TIME_W-1:0]  tim,
  input  logic               all_home,
  input  logic               step,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score,
  output logic               new_hi,
  output logic               extra_life,
  output logic               playing
);

  localparam int unsigned IW = SCORE_W + LEVEL_W + TIME_W + 2;
  localparam int unsigned NW = SCORE_W + 1;

  localparam logic [IW-1:0] SAT =
    {{(IW-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
  localparam logic [NW-1:0] NL_INIT = NW'(LIFE_PTS);
  localparam logic [NW-1:0] NL_STOP = {1'b1, {SCORE_W{1'b0}}};
  localparam logic [TIME_W-1:0] TMAX = TIME_W'(TIME_MAX);

  typedef enum logic {
    S_PLAY = 1'b0,
    S_OVER = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] hi_q, hi_d;
  logic [LEVEL_W-1:0] prev_q, prev_d;
  logic [TIME_W-1:0]  min_q, min_d;
  logic               home_prev_q, home_prev_d;
  logic [NW-1:0]      next_life_q, next_life_d;
  logic               xl_q, xl_d;
  logic               new_hi_q, new_hi_d;

  logic               active;
  logic               lvl_up;
  logic [IW-1:0]      award;
  logic [IW-1:0]      sum;
  logic [IW-1:0]      nl_sum;

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    hi_d        = hi_q;
    prev_d      = prev_q;
    min_d       = min_q;
    home_prev_d = home_prev_q;
    next_life_d = next_life_q;
    xl_d        = 1'b0;
    new_hi_d    = (state_q == S_PLAY) && (score_q > hi_q);

    active = (state_q == S_PLAY) && !new_game && !game_over;
    lvl_up = level > prev_q;

    award = '0;
    if (lvl_up) begin
      award = IW'(level) * IW'(LEVEL_PTS)
            + IW'(min_q) * IW'(TIME_PTS);
    end
    if (all_home && !home_prev_q) begin
      award = award + IW'(HOME_PTS);
    end
    if (step) begin
      award = award + IW'(STEP_PTS);
    end
    sum    = IW'(score_q) + award;
    nl_sum = IW'(next_life_q) + IW'(LIFE_PTS);

    unique case (state_q)
      S_PLAY: if (game_over && !new_game) state_d = S_OVER;
      S_OVER: if (new_game) state_d = S_PLAY;
      default: state_d = S_PLAY;
    endcase

    // leaving a game banks the score before it is cleared
    if ((state_q == S_PLAY) && (new_game || game_over)
        && (score_q > hi_q)) begin
      hi_d = score_q;
    end

    if (new_game) begin
      score_d     = '0;
      prev_d      = '0;
      min_d       = TMAX;
      home_prev_d = 1'b0;
      next_life_d = NL_INIT;
    end else if (active) begin
      score_d = (sum > SAT) ? SAT[SCORE_W-1:0]
                            : sum[SCORE_W-1:0];
      if (lvl_up) begin
        prev_d = level;
        min_d  = TMAX;
      end else begin
        if (level < prev_q) prev_d = level;
        if (tim < min_q) min_d = tim;
      end
      home_prev_d = all_home;
      // sentinel above max score stops further pulses
      if ((LIFE_PTS != 0) && ({1'b0, score_q} >= next_life_q)) begin
        xl_d        = 1'b1;
        next_life_d = (nl_sum > SAT) ? NL_STOP : nl_sum[NW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= S_PLAY;
      score_q     <= '0;
      hi_q        <= '0;
      prev_q      <= '0;
      min_q       <= TMAX;
      home_prev_q <= 1'b0;
      next_life_q <= NL_INIT;
      xl_q        <= 1'b0;
      new_hi_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      hi_q        <= hi_d;
      prev_q      <= prev_d;
      min_q       <= min_d;
      home_prev_q <= home_prev_d;
      next_life_q <= next_life_d;
      xl_q        <= xl_d;
      new_hi_q    <= new_hi_d;
    end
  end

  assign score      = score_q;
  assign hi_score   = hi_q;
  assign new_hi     = new_hi_q;
  assign extra_life = xl_q;
  assign playing    = (state_q == S_PLAY);

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Parametrised game score accumulator for the Frogger datapath; next generation of the single-game score counter.
- Awards points for level completion (level bonus plus remaining-time bonus), all-homes-filled, and forward hops; saturates instead of wrapping.
- Retains a high score across games, flags a new high score, and issues extra-life pulses at score thresholds.
- Sits between game-control FSM and the HUD/digit renderer.

Parameters:
SCORE_W, 16, score and high-score width
LEVEL_W, 4, level input width
TIME_W, 6, countdown timer width
TIME_MAX, 60, timer value at level start; reload value of min-time tracker
LEVEL_PTS, 50, points per level number on level-up
TIME_PTS, 10, points per remaining time unit on level-up
HOME_PTS, 1000, points when all homes filled
STEP_PTS, 10, points per forward hop
LIFE_PTS, 10000, extra-life threshold spacing; 0 disables extra lives

Ports:
clk  in  1  system clock
Reset  in  1  synchronous active-high reset
new_game  in  1  pulse: start new game
game_over  in  1  pulse: end current game
level  in  LEVEL_W  current level number
tim  in  TIME_W  countdown timer value
all_home  in  1  level signal, high while all homes filled
step  in  1  pulse: frog reached a new furthest row
score  out  SCORE_W  current game score
hi_score  out  SCORE_W  best completed-game score
new_hi  out  1  current score exceeds hi_score
extra_life  out  1  one-cycle extra-life award pulse
playing  out  1  high in PLAY state

Behaviour:
- One clock (clk); Reset is synchronous and active-high; all state updates on rising clk only.
- Reset: state=PLAY, score=0, hi_score=0, prev_level=0, min_tim=TIME_MAX, home_d=0, next_life=LIFE_PTS, extra_life=0, new_hi=0.
- States: PLAY, OVER. PLAY->OVER on game_over. OVER->PLAY on new_game. new_game in PLAY restarts (PLAY->PLAY). new_game and game_over same cycle: new_game wins.
- On leaving a game (game_over or new_game while in PLAY): hi_score <= max(hi_score, score). On any new_game: score=0, prev_level=0, min_tim=TIME_MAX, next_life=LIFE_PTS, home_d=0.
- In OVER: score, min_tim, prev_level frozen; step/all_home/level changes ignored; extra_life held 0.
- In PLAY, per cycle award = sum of:
  - level-up (level > prev_level, unsigned): level*LEVEL_PTS + min_tim*TIME_PTS, using registered min_tim (pre-update). Then prev_level<=level, min_tim<=TIME_MAX.
  - level < prev_level: prev_level<=level, no award.
  - all_home rising edge (all_home & ~home_d): HOME_PTS. Exactly once per assertion regardless of duration.
  - step: STEP_PTS.
- Simultaneous events all summed in the same cycle; none are lost.
- min_tim: when no level-up, if tim < min_tim then min_tim<=tim; never increases otherwise.
- Arithmetic in internal width SCORE_W+LEVEL_W+TIME_W+2; score <= min(score+award, 2^SCORE_W-1). Latency: event sampled cycle N, score visible cycle N+1.
- Extra life (LIFE_PTS>0, PLAY): if registered score >= next_life, assert extra_life for one cycle and next_life += LIFE_PTS. At most one pulse per cycle; multiple thresholds crossed produce consecutive pulses on following cycles. If next_life + LIFE_PTS would exceed 2^SCORE_W-1, next_life saturates to all-ones+1 sentinel and no further pulses.
- new_hi: registered, = playing & (score > hi_score), evaluated on registered values.
- Reset mid-game: all state including hi_score cleared next cycle.

Test Plan:
- Reset, tim steps 60->45->50, level 0->1 -> one cycle later score=500 (50+45*10), min_tim reloads 60.
- all_home held high 5 cycles, then low, then high 1 cycle -> score +1000 twice total, not 5000.
- Same cycle: level 1->2, all_home rises, step, min_tim=30 -> score increases by 100+300+1000+10=1410 in one cycle.
- Preload score 65000 via awards, then level 0->15 with min_tim=60 -> score saturates 65535, no wrap.
- Score 9990 then award 20010 (crossing 10000,20000,30000) -> extra_life pulses three consecutive cycles, next_life=40000.
- Game 1 ends at 2000 (game_over), hi_score=2000; new_game, reach 2010 -> new_hi=1; game_over while new_game same cycle at 1500 -> stays PLAY, score=0, hi_score unchanged.
